nes_poll_sequencer: RTL and testbench

Front-end sequencer for the NES controller port, running on the 50 MHz system clock.
- Generates the controller latch and shift-clock waveforms at a fixed poll rate.
- Samples the serial data line and publishes a registered, active-high 8-bit button word.
- Emits a one-cycle frame-valid strobe and a newly-pressed edge vector for the game/input logic downstream.

---
 rtl/nes_pkg.sv | 22 ++
 rtl/nes_sync2.sv | 19 +
 rtl/nes_poll_sequencer.sv | 150 +++++++++++++++
 tb/tb_nes_poll_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller poll sequencer.
package nes_pkg;
  localparam int NES_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    CLK_HI,
    CLK_LO,
    DONE
  } state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
endpackage

// File: rtl/nes_sync2.sv
// Two-flop synchronizer; resets to 1, the idle/not-pressed level of the data line.
module nes_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/nes_poll_sequencer.sv
// NES controller port sequencer: periodic latch/shift-clock generation,
// serial capture, and publication of the button word with new-press edges.
module nes_poll_sequencer
  import nes_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int POLL_HZ      = 60,
  parameter int LATCH_CYC    = 600,
  parameter int HALF_BIT_CYC = 300
) (
  input  logic                CLK,
  input  logic                reset_n,
  input  logic                en,
  input  logic                poll_req,
  input  logic                nes_data,
  output logic                nes_latch,
  output logic                nes_clk,
  output logic [NES_BITS-1:0] buttons,
  output logic [NES_BITS-1:0] pressed,
  output logic                valid,
  output logic                busy
);
  localparam int POLL_CYC = CLK_HZ / POLL_HZ;
  localparam int PH_MAX   = (LATCH_CYC > HALF_BIT_CYC) ? LATCH_CYC : HALF_BIT_CYC;
  localparam int PH_W     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int PT_W     = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;

  localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(LATCH_CYC - 1);
  localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(HALF_BIT_CYC - 1);
  localparam logic [PT_W-1:0] POLL_LAST  = PT_W'(POLL_CYC - 1);

  state_t              state;
  logic [PH_W-1:0]     phase;
  logic [PT_W-1:0]     poll_cnt;
  logic [2:0]          idx;
  logic [NES_BITS-1:0] shift;
  logic [NES_BITS-1:0] shift_nxt;
  logic                data_s;
  logic                tick;
  logic                start;

  nes_sync2 u_sync (
    .clk   (CLK),
    .rst_n (reset_n),
    .d     (nes_data),
    .q     (data_s)
  );

  // Free-running frame timer; frozen while disabled, never touched by poll_req.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
    end else if (en) begin
      poll_cnt <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;
    end
  end

  assign tick  = en && (poll_cnt == POLL_LAST);
  assign start = (state == IDLE) && en && (tick || poll_req);

  // Shift word including the bit captured this cycle, so DONE can publish it directly.
  always_comb begin
    shift_nxt      = shift;
    shift_nxt[idx] = data_s;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      phase     <= '0;
      idx       <= '0;
      shift     <= '0;
      nes_latch <= 1'b0;
      nes_clk   <= 1'b0;
      buttons   <= '0;
      pressed   <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= LATCH;
            phase     <= '0;
            nes_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LATCH: begin
          if (phase == LATCH_LAST) begin
            state     <= GAP;
            phase     <= '0;
            nes_latch <= 1'b0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        GAP: begin
          if (phase == HALF_LAST) begin
            state    <= CLK_HI;
            phase    <= '0;
            nes_clk  <= 1'b1;
            shift[0] <= data_s;
            idx      <= 3'd1;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        CLK_HI: begin
          if (phase == HALF_LAST) begin
            state   <= CLK_LO;
            phase   <= '0;
            nes_clk <= 1'b0;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        CLK_LO: begin
          if (phase == HALF_LAST) begin
            phase <= '0;
            shift <= shift_nxt;
            idx   <= idx + 1'b1;
            // valid/pressed are set on entry so they are visible during DONE itself.
            if (idx == 3'd7) begin
              state   <= DONE;
              buttons <= ~shift_nxt;
              pressed <= ~shift_nxt & ~buttons;
              valid   <= 1'b1;
            end else begin
              state   <= CLK_HI;
              nes_clk <= 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          idx     <= '0;
          valid   <= 1'b0;
          pressed <= '0;
          busy    <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nes_poll_sequencer.sv
// Bench for nes_poll_sequencer: controller model, table of masks with expected
// button/pressed words fed through a scoreboard, plus timing/corner sequences.
module tb_nes_poll_sequencer;
  typedef struct {
    logic [7:0] mask;
    logic [7:0] b;
    logic [7:0] p;
  } vec_t;

  logic       CLK = 1'b0;
  logic       reset_n;
  logic       en;
  logic       poll_req;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic [7:0] pressed;
  logic       valid;
  logic       busy;

  logic [7:0] mask = 8'h00;
  logic [7:0] sr = 8'h00;
  logic       prev_nclk = 1'b0;

  int vectors = 0;
  int errs = 0;
  int nvalid = 0;
  vec_t sb[$];
  vec_t tab[9];

  nes_poll_sequencer #(
    .CLK_HZ      (1000),
    .POLL_HZ     (10),
    .LATCH_CYC   (4),
    .HALF_BIT_CYC(2)
  ) dut (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .en       (en),
    .poll_req (poll_req),
    .nes_data (nes_data),
    .nes_latch(nes_latch),
    .nes_clk  (nes_clk),
    .buttons  (buttons),
    .pressed  (pressed),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 CLK = ~CLK;

  // Controller: parallel load while latched, shift on nes_clk rise, active-low output.
  always @(negedge CLK) begin
    if (nes_latch) sr <= mask;
    else if (nes_clk && !prev_nclk) sr <= {1'b0, sr[7:1]};
    prev_nclk <= nes_clk;
  end
  assign nes_data = ~sr[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    step(1);
    while (!valid && n < budget) begin
      step(1);
      n++;
    end
    if (!valid) begin
      vectors++;
      errs++;
      $display("FAIL wait_valid: no valid within %0d cycles at %0t", budget, $time);
    end
  endtask

  // Scoreboard: every published frame pops one expectation.
  always @(negedge CLK) begin
    vec_t e;
    if (reset_n && valid) begin
      nvalid++;
      if (sb.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL unexpected_valid: buttons %h pressed %h with no expectation", buttons, pressed);
      end else begin
        e = sb.pop_front();
        chk("buttons", 32'(buttons), 32'(e.b));
        chk("pressed", 32'(pressed), 32'(e.p));
      end
    end else if (pressed != 8'h00) begin
      vectors++;
      errs++;
      $display("FAIL pressed_idle: got %h expected 00 while valid low", pressed);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rises, chi, vk, nv0, act;
    logic pc;

    tab[0] = '{8'h00, 8'h00, 8'h00};
    tab[1] = '{8'h09, 8'h09, 8'h09};
    tab[2] = '{8'h09, 8'h09, 8'h00};
    tab[3] = '{8'h88, 8'h88, 8'h80};
    tab[4] = '{8'hFF, 8'hFF, 8'h77};
    tab[5] = '{8'h00, 8'h00, 8'h00};
    tab[6] = '{8'h5A, 8'h5A, 8'h5A};
    tab[7] = '{8'hA5, 8'hA5, 8'hA5};
    tab[8] = '{8'h3C, 8'h3C, 8'h18};

    reset_n  = 1'b0;
    en       = 1'b0;
    poll_req = 1'b0;
    step(3);
    chk("reset_state", 32'({nes_latch, nes_clk, valid, busy, buttons, pressed}), 32'h0);

    // First frame comes from the poll tick after 100 enabled cycles.
    reset_n = 1'b1;
    en      = 1'b1;
    mask    = tab[0].mask;
    sb.push_back(tab[0]);
    step(99);
    chk("latch_before_tick", 32'({nes_latch, busy}), 32'h0);
    step(1);
    chk("latch_at_tick", 32'({nes_latch, busy}), 32'h3);

    lat = 0; rises = 0; chi = 0; vk = -1; pc = 1'b0;
    for (int k = 0; k < 36; k++) begin
      if (nes_latch) lat++;
      if (nes_clk) chi++;
      if (nes_clk && !pc) rises++;
      pc = nes_clk;
      if (valid && vk < 0) vk = k;
      if (k < 35) step(1);
    end
    chk("latch_width", 32'(lat), 32'd4);
    chk("clk_rises", 32'(rises), 32'd7);
    chk("clk_high_cycles", 32'(chi), 32'd14);
    chk("valid_frame_cycle", 32'(vk), 32'd34);
    chk("busy_after_frame", 32'(busy), 32'h0);

    for (int i = 1; i < 9; i++) begin
      mask = tab[i].mask;
      sb.push_back(tab[i]);
      wait_valid(150);
    end

    // poll_req in IDLE starts at once; a second one while busy is dropped.
    step(16);
    sb.push_back('{8'h3C, 8'h3C, 8'h00});
    nv0 = nvalid;
    poll_req = 1'b1;
    step(1);
    poll_req = 1'b0;
    chk("poll_req_latch", 32'({nes_latch, busy}), 32'h3);
    step(9);
    chk("busy_mid_frame", 32'(busy), 32'h1);
    poll_req = 1'b1;
    step(1);
    poll_req = 1'b0;
    step(38);
    chk("single_valid_poll", 32'(nvalid - nv0), 32'd1);
    chk("idle_before_tick", 32'(nes_latch), 32'h0);
    sb.push_back('{8'h3C, 8'h3C, 8'h00});
    step(1);
    chk("timer_unaffected", 32'(nes_latch), 32'h1);
    wait_valid(100);

    // Reset in the middle of the first CLK_HI phase.
    mask = 8'h81;
    step(66);
    chk("frame_started", 32'(nes_latch), 32'h1);
    step(7);
    chk("clk_hi_before_reset", 32'(nes_clk), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("reset_async", 32'({nes_latch, nes_clk, valid, busy, buttons, pressed}), 32'h0);
    step(3);
    reset_n = 1'b1;
    sb.push_back('{8'h81, 8'h81, 8'h81});
    wait_valid(200);

    // Disabled: no activity and the timer holds its count.
    en = 1'b0;
    act = 0;
    for (int k = 0; k < 300; k++) begin
      step(1);
      if (nes_latch || busy) act++;
    end
    chk("en_low_idle", 32'(act), 32'd0);
    en = 1'b1;
    sb.push_back('{8'h81, 8'h81, 8'h00});
    step(65);
    chk("timer_frozen_hold", 32'(nes_latch), 32'h0);
    step(1);
    chk("timer_frozen_resume", 32'(nes_latch), 32'h1);
    step(10);
    en = 1'b0;
    nv0 = nvalid;
    step(40);
    chk("en_drop_single_valid", 32'(nvalid - nv0), 32'd1);
    chk("en_drop_idle", 32'({nes_latch, busy}), 32'h0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
